ps2_scan_sequencer: RTL and testbench

Receives raw PS/2 frames from the keyboard pins, validates them, and tracks make/break/extended prefixes and shift state. Delivers clean make-code events to the printer path through a small FIFO with a valid/ready handshake. It sits between the keyboard pins and the ASCII decode/printer logic, and replaces ad-hoc frame counting with a sequenced, error-checked front end.

---
 rtl/ps2_scan_sequencer.sv | 228 ++++++++++++++++++++++
 tb/tb_ps2_scan_sequencer.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_scan_sequencer.sv
// PS/2 keyboard front end: synchronizes the pins, frames and checks each byte,
// tracks E0/F0 prefixes and shift state, and queues make codes in a small FIFO.
module ps2_scan_sequencer #(
   parameter int FIFO_DEPTH     = 4,
   parameter int TIMEOUT_CYCLES = 5000
) (
   input  logic       clk_k,
   input  logic       reset_l,
   input  logic       ps2_clk,
   input  logic       ps2_data,
   output logic [7:0] code_out,
   output logic       code_ext,
   output logic       code_shift,
   output logic       code_valid,
   input  logic       code_ready,
   output logic       parity_error,
   output logic       frame_error,
   output logic       overflow
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);

   typedef enum logic {F_IDLE, F_RECV} frame_state_t;
   typedef enum logic [1:0] {D_BASE, D_EXT, D_BRK, D_EXT_BRK} dec_state_t;

   // clk_sync: [0] first stage, [1] synced, [2] previous synced value
   logic [2:0]       clk_sync_q, clk_sync_d;
   logic [1:0]       data_sync_q, data_sync_d;
   logic             fall, data_bit;

   frame_state_t     frame_q, frame_d;
   logic [3:0]       bit_cnt_q, bit_cnt_d;
   logic [7:0]       shreg_q, shreg_d;
   logic             par_q, par_d;
   logic [TO_W-1:0]  idle_cnt_q, idle_cnt_d;
   logic             byte_strobe_q, byte_strobe_d;
   logic [7:0]       byte_q, byte_d;
   logic             parity_error_q, parity_error_d;
   logic             frame_error_q, frame_error_d;

   dec_state_t       dec_q, dec_d;
   logic             lshift_q, lshift_d;
   logic             rshift_q, rshift_d;
   logic             push;
   logic [9:0]       push_entry;

   logic [9:0]       mem_q [FIFO_DEPTH];
   logic [9:0]       mem_d [FIFO_DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             overflow_q, overflow_d;
   logic             empty, full, pop, wr_en;

   assign fall     = clk_sync_q[2] & ~clk_sync_q[1];
   assign data_bit = data_sync_q[1];

   always_comb begin
      clk_sync_d  = {clk_sync_q[1:0], ps2_clk};
      data_sync_d = {data_sync_q[0], ps2_data};
   end

   always_comb begin
      frame_d        = frame_q;
      bit_cnt_d      = bit_cnt_q;
      shreg_d        = shreg_q;
      par_d          = par_q;
      idle_cnt_d     = idle_cnt_q;
      byte_strobe_d  = 1'b0;
      byte_d         = byte_q;
      parity_error_d = 1'b0;
      frame_error_d  = 1'b0;
      case (frame_q)
         F_IDLE: begin
            idle_cnt_d = '0;
            if (fall && !data_bit) begin
               frame_d   = F_RECV;
               bit_cnt_d = '0;
            end
         end
         default: begin
            if (fall) begin
               idle_cnt_d = '0;
               bit_cnt_d  = bit_cnt_q + 4'd1;
               if (bit_cnt_q < 4'd8) begin
                  shreg_d = {data_bit, shreg_q[7:1]};
               end else if (bit_cnt_q == 4'd8) begin
                  par_d = data_bit;
               end else begin
                  frame_d   = F_IDLE;
                  bit_cnt_d = '0;
                  // odd parity: data ones plus parity bit must be odd
                  if (!data_bit) begin
                     frame_error_d = 1'b1;
                  end else if (!(^{shreg_q, par_q})) begin
                     parity_error_d = 1'b1;
                  end else begin
                     byte_strobe_d = 1'b1;
                     byte_d        = shreg_q;
                  end
               end
            end else if (idle_cnt_q == TO_W'(TIMEOUT_CYCLES)) begin
               frame_error_d = 1'b1;
               frame_d       = F_IDLE;
               bit_cnt_d     = '0;
               idle_cnt_d    = '0;
            end else begin
               idle_cnt_d = idle_cnt_q + TO_W'(1);
            end
         end
      endcase
   end

   always_comb begin
      dec_d      = dec_q;
      lshift_d   = lshift_q;
      rshift_d   = rshift_q;
      push       = 1'b0;
      push_entry = {1'b0, lshift_q | rshift_q, byte_q};
      if (parity_error_q || frame_error_q) begin
         dec_d = D_BASE;
      end else if (byte_strobe_q) begin
         case (dec_q)
            D_BASE: begin
               case (byte_q)
                  8'hE0: dec_d = D_EXT;
                  8'hF0: dec_d = D_BRK;
                  8'h12: lshift_d = 1'b1;
                  8'h59: rshift_d = 1'b1;
                  8'hAA, 8'hFA, 8'hEE, 8'h00, 8'hFF: ;
                  default: push = 1'b1;
               endcase
            end
            D_EXT: begin
               // E0 12 / E0 59 are the keyboard's fake shifts, never real keys
               case (byte_q)
                  8'hE0: dec_d = D_EXT;
                  8'hF0: dec_d = D_EXT_BRK;
                  8'h12, 8'h59: dec_d = D_BASE;
                  default: begin
                     push       = 1'b1;
                     push_entry = {1'b1, lshift_q | rshift_q, byte_q};
                     dec_d      = D_BASE;
                  end
               endcase
            end
            D_BRK: begin
               if (byte_q == 8'h12) lshift_d = 1'b0;
               if (byte_q == 8'h59) rshift_d = 1'b0;
               dec_d = D_BASE;
            end
            default: dec_d = D_BASE;
         endcase
      end
   end

   assign empty = (count_q == '0);
   assign full  = (count_q == CNT_W'(FIFO_DEPTH));
   assign pop   = ~empty & code_ready;
   assign wr_en = push & (~full | pop);

   always_comb begin
      mem_d      = mem_q;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      count_d    = count_q;
      overflow_d = push & full & ~pop;
      if (wr_en) begin
         mem_d[wr_ptr_q] = push_entry;
         wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
      if (wr_en && !pop) count_d = count_q + CNT_W'(1);
      else if (!wr_en && pop) count_d = count_q - CNT_W'(1);
   end

   always_ff @(posedge clk_k or negedge reset_l) begin
      if (!reset_l) begin
         clk_sync_q     <= 3'b111;
         data_sync_q    <= 2'b11;
         frame_q        <= F_IDLE;
         bit_cnt_q      <= '0;
         shreg_q        <= '0;
         par_q          <= 1'b0;
         idle_cnt_q     <= '0;
         byte_strobe_q  <= 1'b0;
         byte_q         <= '0;
         parity_error_q <= 1'b0;
         frame_error_q  <= 1'b0;
         dec_q          <= D_BASE;
         lshift_q       <= 1'b0;
         rshift_q       <= 1'b0;
         for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
         wr_ptr_q       <= '0;
         rd_ptr_q       <= '0;
         count_q        <= '0;
         overflow_q     <= 1'b0;
      end else begin
         clk_sync_q     <= clk_sync_d;
         data_sync_q    <= data_sync_d;
         frame_q        <= frame_d;
         bit_cnt_q      <= bit_cnt_d;
         shreg_q        <= shreg_d;
         par_q          <= par_d;
         idle_cnt_q     <= idle_cnt_d;
         byte_strobe_q  <= byte_strobe_d;
         byte_q         <= byte_d;
         parity_error_q <= parity_error_d;
         frame_error_q  <= frame_error_d;
         dec_q          <= dec_d;
         lshift_q       <= lshift_d;
         rshift_q       <= rshift_d;
         mem_q          <= mem_d;
         wr_ptr_q       <= wr_ptr_d;
         rd_ptr_q       <= rd_ptr_d;
         count_q        <= count_d;
         overflow_q     <= overflow_d;
      end
   end

   assign code_valid   = ~empty;
   assign {code_ext, code_shift, code_out} = empty ? 10'd0 : mem_q[rd_ptr_q];
   assign parity_error = parity_error_q;
   assign frame_error  = frame_error_q;
   assign overflow     = overflow_q;

endmodule

// File: tb/tb_ps2_scan_sequencer.sv
// Bench for ps2_scan_sequencer: drives PS/2 frames on the pins and compares
// delivered events against a scoreboard queue plus error/overflow pulse counts.
module tb_ps2_scan_sequencer;

   localparam int TIMEOUT_CYCLES = 5000;

   logic       clk_k = 1'b0;
   logic       reset_l;
   logic       ps2_clk;
   logic       ps2_data;
   logic [7:0] code_out;
   logic       code_ext;
   logic       code_shift;
   logic       code_valid;
   logic       code_ready;
   logic       parity_error;
   logic       frame_error;
   logic       overflow;

   int errors = 0;
   int checks = 0;
   int perr_cnt = 0;
   int ferr_cnt = 0;
   int ovf_cnt = 0;
   int valid_cycles = 0;
   logic [9:0] sb[$];
   bit         hold_prev = 1'b0;
   logic [9:0] prev_entry = '0;

   typedef struct {
      logic [7:0] code;
      bit         flip_par;
      bit         bad_stop;
      bit         exp_push;
      logic [9:0] exp_entry;
      int         exp_perr;
      int         exp_ferr;
   } vec_t;

   vec_t vecs[$];

   ps2_scan_sequencer #(.FIFO_DEPTH(4), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)) dut (
      .clk_k       (clk_k),
      .reset_l     (reset_l),
      .ps2_clk     (ps2_clk),
      .ps2_data    (ps2_data),
      .code_out    (code_out),
      .code_ext    (code_ext),
      .code_shift  (code_shift),
      .code_valid  (code_valid),
      .code_ready  (code_ready),
      .parity_error(parity_error),
      .frame_error (frame_error),
      .overflow    (overflow)
   );

   always #5 clk_k = ~clk_k;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic waitCycles(input int n);
      repeat (n) @(posedge clk_k);
      #1;
   endtask

   // nbits < 11 sends only the leading part of the frame
   task automatic applyStimulus(input logic [7:0] b, input bit flip_par, input bit bad_stop,
                                input int nbits);
      logic [10:0] bits;
      bits = {~bad_stop, (~^b) ^ flip_par, b, 1'b0};
      for (int i = 0; i < nbits; i++) begin
         ps2_data = bits[i];
         waitCycles(4);
         ps2_clk = 1'b0;
         waitCycles(8);
         ps2_clk = 1'b1;
         waitCycles(4);
      end
   endtask

   function automatic vec_t mk(input logic [7:0] code, input bit fp, input bit bs,
                               input bit ep, input logic [9:0] ee, input int pe, input int fe);
      vec_t v;
      v.code = code; v.flip_par = fp; v.bad_stop = bs;
      v.exp_push = ep; v.exp_entry = ee; v.exp_perr = pe; v.exp_ferr = fe;
      return v;
   endfunction

   // Scoreboard pop and pulse accounting, sampled on the falling clock edge
   always @(negedge clk_k) begin
      if (reset_l) begin
         if (parity_error) perr_cnt++;
         if (frame_error) ferr_cnt++;
         if (overflow) ovf_cnt++;
         if (code_valid) valid_cycles++;
         if (hold_prev && code_valid)
            checkOutput("hold_stable", {22'd0, code_ext, code_shift, code_out}, {22'd0, prev_entry});
         if (code_valid && code_ready) begin
            if (sb.size() == 0) begin
               checkOutput("unexpected_pop", {22'd0, code_ext, code_shift, code_out}, 32'hFFFF_FFFF);
            end else begin
               checkOutput("pop_entry", {22'd0, code_ext, code_shift, code_out}, {22'd0, sb.pop_front()});
            end
         end
         hold_prev  = code_valid && !code_ready;
         prev_entry = {code_ext, code_shift, code_out};
      end else begin
         hold_prev = 1'b0;
      end
   end

   initial begin
      int p0, f0, o0, v0;

      vecs.push_back(mk(8'h12, 0, 0, 0, 10'h000, 0, 0));
      vecs.push_back(mk(8'h1C, 0, 0, 1, 10'h11C, 0, 0));
      vecs.push_back(mk(8'hF0, 0, 0, 0, 10'h000, 0, 0));
      vecs.push_back(mk(8'h12, 0, 0, 0, 10'h000, 0, 0));
      vecs.push_back(mk(8'h1C, 0, 0, 1, 10'h01C, 0, 0));
      vecs.push_back(mk(8'hE0, 0, 0, 0, 10'h000, 0, 0));
      vecs.push_back(mk(8'h75, 0, 0, 1, 10'h275, 0, 0));
      vecs.push_back(mk(8'hE0, 0, 0, 0, 10'h000, 0, 0));
      vecs.push_back(mk(8'hF0, 0, 0, 0, 10'h000, 0, 0));
      vecs.push_back(mk(8'h75, 0, 0, 0, 10'h000, 0, 0));
      vecs.push_back(mk(8'h1C, 1, 0, 0, 10'h000, 1, 0));
      vecs.push_back(mk(8'hF0, 0, 0, 0, 10'h000, 0, 0));
      vecs.push_back(mk(8'h32, 1, 0, 0, 10'h000, 1, 0));
      vecs.push_back(mk(8'h1C, 0, 0, 1, 10'h01C, 0, 0));
      vecs.push_back(mk(8'h1C, 0, 1, 0, 10'h000, 0, 1));
      vecs.push_back(mk(8'h59, 0, 0, 0, 10'h000, 0, 0));
      vecs.push_back(mk(8'hE0, 0, 0, 0, 10'h000, 0, 0));
      vecs.push_back(mk(8'h12, 0, 0, 0, 10'h000, 0, 0));
      vecs.push_back(mk(8'h21, 0, 0, 1, 10'h121, 0, 0));
      vecs.push_back(mk(8'hF0, 0, 0, 0, 10'h000, 0, 0));
      vecs.push_back(mk(8'h59, 0, 0, 0, 10'h000, 0, 0));
      vecs.push_back(mk(8'hAA, 0, 0, 0, 10'h000, 0, 0));
      vecs.push_back(mk(8'h24, 0, 0, 1, 10'h024, 0, 0));

      reset_l = 1'b0; ps2_clk = 1'b1; ps2_data = 1'b1; code_ready = 1'b1;
      waitCycles(3);
      checkOutput("reset_valid", {31'd0, code_valid}, 32'd0);
      checkOutput("reset_code", {22'd0, code_ext, code_shift, code_out}, 32'd0);
      checkOutput("reset_pulses", {29'd0, parity_error, frame_error, overflow}, 32'd0);
      reset_l = 1'b1;
      waitCycles(5);

      // First event: code_valid high for exactly one cycle with ready held
      v0 = valid_cycles; p0 = perr_cnt; f0 = ferr_cnt;
      sb.push_back(10'h01C);
      applyStimulus(8'h1C, 0, 0, 11);
      waitCycles(8);
      checkOutput("first_valid_width", valid_cycles - v0, 1);
      checkOutput("first_drained", sb.size(), 0);
      checkOutput("first_no_err", (perr_cnt - p0) + (ferr_cnt - f0), 0);

      foreach (vecs[i]) begin
         if (vecs[i].exp_push) sb.push_back(vecs[i].exp_entry);
         p0 = perr_cnt; f0 = ferr_cnt;
         applyStimulus(vecs[i].code, vecs[i].flip_par, vecs[i].bad_stop, 11);
         waitCycles(8);
         checkOutput($sformatf("vec%0d_perr", i), perr_cnt - p0, vecs[i].exp_perr);
         checkOutput($sformatf("vec%0d_ferr", i), ferr_cnt - f0, vecs[i].exp_ferr);
         checkOutput($sformatf("vec%0d_drained", i), sb.size(), 0);
      end

      // Held FIFO: shift and break bytes produce no entries
      code_ready = 1'b0;
      o0 = ovf_cnt;
      sb.push_back(10'h11C);
      sb.push_back(10'h01C);
      applyStimulus(8'h12, 0, 0, 11);
      applyStimulus(8'h1C, 0, 0, 11);
      applyStimulus(8'hF0, 0, 0, 11);
      applyStimulus(8'h1C, 0, 0, 11);
      applyStimulus(8'hF0, 0, 0, 11);
      applyStimulus(8'h12, 0, 0, 11);
      applyStimulus(8'h1C, 0, 0, 11);
      waitCycles(8);
      checkOutput("hold_valid", {31'd0, code_valid}, 32'd1);
      checkOutput("hold_head", {22'd0, code_ext, code_shift, code_out}, 32'h11C);
      checkOutput("hold_no_ovf", ovf_cnt - o0, 0);
      code_ready = 1'b1;
      waitCycles(6);
      checkOutput("hold_drained", sb.size(), 0);
      checkOutput("hold_empty", {21'd0, code_valid, code_ext, code_shift, code_out}, 32'd0);

      // Overflow on the fifth make with the consumer stalled
      code_ready = 1'b0;
      o0 = ovf_cnt;
      sb.push_back(10'h01C); sb.push_back(10'h032);
      sb.push_back(10'h021); sb.push_back(10'h023);
      applyStimulus(8'h1C, 0, 0, 11);
      applyStimulus(8'h32, 0, 0, 11);
      applyStimulus(8'h21, 0, 0, 11);
      applyStimulus(8'h23, 0, 0, 11);
      applyStimulus(8'h24, 0, 0, 11);
      waitCycles(8);
      checkOutput("ovf_pulse", ovf_cnt - o0, 1);
      checkOutput("ovf_head", {22'd0, code_ext, code_shift, code_out}, 32'h01C);
      code_ready = 1'b1;
      waitCycles(10);
      checkOutput("ovf_drained", sb.size(), 0);
      checkOutput("ovf_empty", {31'd0, code_valid}, 32'd0);

      // Abandoned partial frame recovered by the idle timeout
      f0 = ferr_cnt;
      applyStimulus(8'h1C, 0, 0, 5);
      waitCycles(TIMEOUT_CYCLES + 20);
      checkOutput("timeout_ferr", ferr_cnt - f0, 1);
      sb.push_back(10'h01C);
      applyStimulus(8'h1C, 0, 0, 11);
      waitCycles(8);
      checkOutput("timeout_recover", sb.size(), 0);
      checkOutput("timeout_ferr_once", ferr_cnt - f0, 1);

      // Reset mid-frame with a queued entry and shift held
      code_ready = 1'b0;
      applyStimulus(8'h12, 0, 0, 11);
      sb.push_back(10'h132);
      applyStimulus(8'h32, 0, 0, 11);
      waitCycles(6);
      checkOutput("prereset_valid", {31'd0, code_valid}, 32'd1);
      applyStimulus(8'h1C, 0, 0, 4);
      reset_l = 1'b0;
      #1;
      checkOutput("midreset_outputs",
                  {20'd0, code_valid, code_ext, code_shift, code_out, parity_error, frame_error, overflow},
                  32'd0);
      sb.delete();
      waitCycles(2);
      reset_l = 1'b1;
      code_ready = 1'b1;
      waitCycles(5);
      f0 = ferr_cnt;
      sb.push_back(10'h01C);
      applyStimulus(8'h1C, 0, 0, 11);
      waitCycles(8);
      checkOutput("postreset_decode", sb.size(), 0);
      checkOutput("postreset_no_ferr", ferr_cnt - f0, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
